// File: rtl/traffic_lights_pkg.sv
`default_nettype none
// ============================================================================
// Module : traffic_lights_pkg
// Brief  : Shared types for the traffic_lights command front-end: command
//          encodings of the traffic_lights cmd port, request op encodings,
//          bus widths and the CFG_START step-walk helpers.
// Rev    : 1.0  initial release
// ============================================================================
package traffic_lights_pkg;

  localparam int CMD_W  = 3;
  localparam int DATA_W = 16;

  typedef enum logic [CMD_W-1:0] {
    CMD_ON      = 3'd0,
    CMD_OFF     = 3'd1,
    CMD_NOTRANS = 3'd2,
    CMD_SET_G   = 3'd3,
    CMD_SET_R   = 3'd4,
    CMD_SET_Y   = 3'd5
  } cmd_t;

  typedef enum logic [1:0] {
    OP_CFG_START = 2'd0,
    OP_OFF       = 2'd1,
    OP_START     = 2'd2,
    OP_HOLD      = 2'd3
  } op_t;

  // CFG_START walks steps 0..4: NOTRANS, SET_G, SET_R, SET_Y, ON.
  localparam logic [2:0] c_CFG_LAST_STEP = 3'd4;

  // Next CFG_START step, hopping over period-set commands whose period is 0.
  function automatic logic [2:0] next_cfg_step(input logic [2:0] step,
                                               input logic       g_set,
                                               input logic       r_set,
                                               input logic       y_set);
    logic [2:0] s;
    s = step + 3'd1;
    if (s == 3'd1 && !g_set) s = 3'd2;
    if (s == 3'd2 && !r_set) s = 3'd3;
    if (s == 3'd3 && !y_set) s = 3'd4;
    return s;
  endfunction

  // Command emitted for a given op at a given step.
  function automatic cmd_t op_cmd(input op_t op, input logic [2:0] step);
    cmd_t c;
    case (op)
      OP_CFG_START: begin
        case (step)
          3'd0:    c = CMD_NOTRANS;
          3'd1:    c = CMD_SET_G;
          3'd2:    c = CMD_SET_R;
          3'd3:    c = CMD_SET_Y;
          default: c = CMD_ON;
        endcase
      end
      OP_OFF:   c = CMD_OFF;
      OP_START: c = CMD_ON;
      default:  c = CMD_NOTRANS;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_lights_rr_arb.sv
`default_nettype none
// ============================================================================
// Module : traffic_lights_rr_arb
// Brief  : NUM_REQ-way round-robin arbiter. The search starts one past the
//          last accepted index; the pointer moves only when i_update is high.
// Ports  : clk_i, arst_n_i     clock, async active-low reset
//          i_req[NUM_REQ]      request vector
//          i_update            commit current winner as new pointer
//          o_grant[NUM_REQ]    one-hot winner (zero when no request)
//          o_grant_idx         winner index
// Rev    : 1.0  initial release
// ============================================================================
module traffic_lights_rr_arb #(
  parameter int NUM_REQ = 2
) (
  input  logic                       clk_i,
  input  logic                       arst_n_i,
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic                       i_update,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_idx
);

  localparam int c_IDX_W = $clog2(NUM_REQ);

  logic [c_IDX_W-1:0] r_ptr;
  logic [NUM_REQ-1:0] w_grant;
  logic [c_IDX_W-1:0] w_idx;
  logic               w_found;

  always_comb begin
    w_grant = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!w_found && i_req[(int'(r_ptr) + i) % NUM_REQ]) begin
        w_found = 1'b1;
        w_idx   = c_IDX_W'((int'(r_ptr) + i) % NUM_REQ);
        w_grant[(int'(r_ptr) + i) % NUM_REQ] = 1'b1;
      end
    end
  end

  // Reset to the last index so requester 0 wins the first arbitration.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_ptr <= c_IDX_W'(NUM_REQ - 1);
    end else if (i_update && w_found) begin
      r_ptr <= w_idx;
    end
  end

  assign o_grant     = w_grant;
  assign o_grant_idx = w_idx;

endmodule
`default_nettype wire

// File: rtl/traffic_lights_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module : traffic_lights_cfg_sequencer
// Brief  : Shares the single traffic_lights command port between NUM_REQ
//          requesters, expands each request into its command list with
//          CMD_GAP idle cycles after every command, and preempts any sequence
//          on a rising edge of force_off_i with a single OFF command.
// Ports  : clk_i, arst_n_i           clock, async active-low reset
//          req_valid_i/req_ready_o   per-requester handshake
//          req_op_i                  2-bit op per requester
//          req_green/red/yellow_i    16-bit periods per requester, 0 = keep
//          force_off_i               emergency off (level)
//          cmd_type_o/valid/data_o   to traffic_lights command port
//          busy_o                    sequence in progress (incl. gaps)
//          grant_id_o                owner of current/last sequence
// Rev    : 1.0  initial release
// ============================================================================
module traffic_lights_cfg_sequencer
  import traffic_lights_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int CMD_GAP = 2
) (
  input  logic                       clk_i,
  input  logic                       arst_n_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic [2*NUM_REQ-1:0]       req_op_i,
  input  logic [16*NUM_REQ-1:0]      req_green_i,
  input  logic [16*NUM_REQ-1:0]      req_red_i,
  input  logic [16*NUM_REQ-1:0]      req_yellow_i,
  input  logic                       force_off_i,
  output logic [2:0]                 cmd_type_o,
  output logic                       cmd_valid_o,
  output logic [15:0]                cmd_data_o,
  output logic                       busy_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_id_o
);

  localparam int c_IDX_W = $clog2(NUM_REQ);
  localparam int c_GAP_W = $clog2(CMD_GAP + 1);
  localparam logic [c_GAP_W-1:0] c_GAP_LOAD = c_GAP_W'(CMD_GAP - 1);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_EMIT  = 2'd1;
  localparam logic [1:0] c_ST_GAP   = 2'd2;
  localparam logic [1:0] c_ST_FORCE = 2'd3;

  logic [1:0]         r_state;
  logic [2:0]         r_step;
  logic [c_GAP_W-1:0] r_gap_cnt;
  op_t                r_op;
  logic [DATA_W-1:0]  r_green;
  logic [DATA_W-1:0]  r_red;
  logic [DATA_W-1:0]  r_yellow;
  logic [c_IDX_W-1:0] r_grant_id;
  logic               r_force_q;
  logic               r_rst_done;

  logic [NUM_REQ-1:0] w_arb_grant;
  logic [c_IDX_W-1:0] w_win_idx;
  logic               w_force_rise;
  logic               w_can_grant;
  logic               w_accept;
  logic               w_last;
  cmd_t               w_cmd;

  assign w_force_rise = force_off_i & ~r_force_q;
  // r_rst_done keeps ready low while reset is asserted even though the FSM
  // sits in IDLE. force_off_i high (level) also covers the rising-edge cycle.
  assign w_can_grant  = r_rst_done && (r_state == c_ST_IDLE) && !force_off_i;
  assign w_accept     = w_can_grant && (|req_valid_i);
  assign req_ready_o  = w_arb_grant & {NUM_REQ{w_can_grant}};

  traffic_lights_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk_i       (clk_i),
    .arst_n_i    (arst_n_i),
    .i_req       (req_valid_i),
    .i_update    (w_accept),
    .o_grant     (w_arb_grant),
    .o_grant_idx (w_win_idx)
  );

  assign w_last = (r_op != OP_CFG_START) || (r_step == c_CFG_LAST_STEP);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state    <= c_ST_IDLE;
      r_step     <= '0;
      r_gap_cnt  <= '0;
      r_op       <= OP_CFG_START;
      r_green    <= '0;
      r_red      <= '0;
      r_yellow   <= '0;
      r_grant_id <= '0;
      r_force_q  <= 1'b0;
      r_rst_done <= 1'b0;
    end else begin
      r_force_q  <= force_off_i;
      r_rst_done <= 1'b1;
      if (w_force_rise) begin
        // Preempts every state, including a pending GAP->EMIT step.
        r_state <= c_ST_FORCE;
      end else begin
        case (r_state)
          c_ST_IDLE: begin
            if (w_accept) begin
              r_state    <= c_ST_EMIT;
              r_step     <= '0;
              r_op       <= op_t'(req_op_i[2*w_win_idx +: 2]);
              r_green    <= req_green_i[DATA_W*w_win_idx +: DATA_W];
              r_red      <= req_red_i[DATA_W*w_win_idx +: DATA_W];
              r_yellow   <= req_yellow_i[DATA_W*w_win_idx +: DATA_W];
              r_grant_id <= w_win_idx;
            end
          end
          c_ST_EMIT: begin
            r_state   <= c_ST_GAP;
            r_gap_cnt <= c_GAP_LOAD;
          end
          c_ST_FORCE: begin
            // Re-labelling the op as OFF makes the following GAP end in IDLE.
            r_state   <= c_ST_GAP;
            r_gap_cnt <= c_GAP_LOAD;
            r_op      <= OP_OFF;
            r_step    <= '0;
          end
          c_ST_GAP: begin
            if (r_gap_cnt == '0) begin
              if (w_last) begin
                r_state <= c_ST_IDLE;
              end else begin
                r_state <= c_ST_EMIT;
                r_step  <= next_cfg_step(r_step, |r_green, |r_red, |r_yellow);
              end
            end else begin
              r_gap_cnt <= r_gap_cnt - c_GAP_W'(1);
            end
          end
          default: r_state <= c_ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    w_cmd       = op_cmd(r_op, r_step);
    cmd_valid_o = 1'b0;
    cmd_type_o  = '0;
    cmd_data_o  = '0;
    if (r_state == c_ST_FORCE) begin
      cmd_valid_o = 1'b1;
      cmd_type_o  = CMD_OFF;
    end else if (r_state == c_ST_EMIT) begin
      cmd_valid_o = 1'b1;
      cmd_type_o  = w_cmd;
      case (w_cmd)
        CMD_SET_G: cmd_data_o = r_green;
        CMD_SET_R: cmd_data_o = r_red;
        CMD_SET_Y: cmd_data_o = r_yellow;
        default:   cmd_data_o = '0;
      endcase
    end
  end

  assign busy_o     = (r_state != c_ST_IDLE);
  assign grant_id_o = r_grant_id;

endmodule
`default_nettype wire
